// File: rtl/present_inv_key_sched_pkg.sv
// rtl/present_inv_key_sched_pkg.sv - PRESENT-80 key schedule widths, S-box tables, FSM states
package present_inv_key_sched_pkg;

  localparam int KEY_W = 80;
  localparam int RK_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
    return SBOX_INV[x];
  endfunction

endpackage

// File: rtl/present_inv_key_sched_key_step.sv
// rtl/present_inv_key_sched_key_step.sv - one forward or inverse PRESENT-80 key-register update
// Purely combinational; inv_i selects the inverse so one instance serves both walk directions.
module present_key_step
  import present_inv_key_sched_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       rc_i,
  input  logic             inv_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] fwd_k;
  logic [KEY_W-1:0] inv_t;
  logic [KEY_W-1:0] inv_k;

  always_comb begin
    fwd_k          = {key_i[18:0], key_i[79:19]};
    fwd_k[79:76]   = sbox4(fwd_k[79:76]);
    fwd_k[19:15]   = fwd_k[19:15] ^ rc_i;

    // Undo the forward ops in reverse order; the final right-rotate by 61 undoes the left-rotate.
    inv_t          = key_i;
    inv_t[19:15]   = inv_t[19:15] ^ rc_i;
    inv_t[79:76]   = sbox4_inv(inv_t[79:76]);
    inv_k          = {inv_t[60:0], inv_t[79:61]};

    key_o          = inv_i ? inv_k : fwd_k;
  end

endmodule

// File: rtl/present_inv_key_sched.sv
// rtl/present_inv_key_sched.sv - PRESENT-80 round keys in reverse order (K32 .. K1) over valid/ready
// Optional PRESENT_LAST_KEY_LOAD_EN adds key_is_last_i to load the final key state and skip the forward walk.
module present_inv_key_sched
  import present_inv_key_sched_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int IDX_W  = 6
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
`ifdef PRESENT_LAST_KEY_LOAD_EN
  input  logic             key_is_last_i,
`endif
  output logic             busy_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic [RK_W-1:0]  rk_out_o,
  output logic [IDX_W-1:0] rk_idx_o,
  output logic             rk_last_o
);

  localparam logic [4:0]       CNT_LAST  = 5'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             step_inv;
  logic [4:0]       step_rc;
  logic [KEY_W-1:0] step_key;
  logic             beat;

  // In EMIT the round constant is rk_idx-1; low 5 bits of idx (32 -> 0) minus one gives 31 correctly.
  assign step_inv = (state_q == ST_EMIT);
  assign step_rc  = step_inv ? (idx_q[4:0] - 5'd1) : cnt_q;

  present_key_step u_step (
    .key_i (key_q),
    .rc_i  (step_rc),
    .inv_i (step_inv),
    .key_o (step_key)
  );

  assign beat = (state_q == ST_EMIT) && rk_ready_i;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          key_d = key_i;
          cnt_d = 5'd1;
`ifdef PRESENT_LAST_KEY_LOAD_EN
          if (key_is_last_i) begin
            idx_d   = IDX_FIRST;
            state_d = ST_EMIT;
          end else begin
            state_d = ST_FWD;
          end
`else
          state_d = ST_FWD;
`endif
        end
      end
      ST_FWD: begin
        key_d = step_key;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_EMIT;
          idx_d   = IDX_FIRST;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_EMIT: begin
        if (beat) begin
          if (idx_q == IDX_ONE) begin
            state_d = ST_IDLE;
          end else begin
            key_d = step_key;
            idx_d = idx_q - IDX_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign rk_valid_o = (state_q == ST_EMIT);
  assign rk_out_o   = key_q[79:16];
  assign rk_idx_o   = idx_q;
  assign rk_last_o  = rk_valid_o && (idx_q == IDX_ONE);

endmodule

// File: tb/tb_present_inv_key_sched.sv
// tb/tb_present_inv_key_sched.sv - scoreboard bench for the reverse-order PRESENT-80 key schedule
// Expected keys come from a forward reference generator plus hand-derived constants for the zero key.
module tb_present_inv_key_sched;

  localparam int ROUNDS = 32;
  localparam int IDX_W  = 6;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [79:0]      key_in;
`ifdef PRESENT_LAST_KEY_LOAD_EN
  logic             key_is_last;
`endif
  logic             busy;
  logic             rk_valid;
  logic             rk_ready;
  logic [63:0]      rk_out;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_last;

  typedef struct packed {
    logic [63:0]      rk;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   beats    = 0;
  bit   mon_en   = 0;

  present_inv_key_sched #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
`ifdef PRESENT_LAST_KEY_LOAD_EN
    .key_is_last_i (key_is_last),
`endif
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .key_i      (key_in),
    .busy_o     (busy),
    .rk_valid_o (rk_valid),
    .rk_ready_i (rk_ready),
    .rk_out_o   (rk_out),
    .rk_idx_o   (rk_idx),
    .rk_last_o  (rk_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = ref_sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  task automatic push_expected(input logic [79:0] key, input bit zero_consts);
    logic [63:0] rks [1:32];
    logic [79:0] k;
    exp_t        e;
    k = key;
    for (int i = 1; i <= ROUNDS; i++) begin
      rks[i] = k[79:16];
      if (i < ROUNDS) k = fwd_step(k, 5'(i));
    end
    if (zero_consts) begin
      rks[32] = 64'h6dab31744f41d700;
      rks[2]  = 64'hc000000000000000;
      rks[1]  = 64'h0;
    end
    for (int i = ROUNDS; i >= 1; i--) begin
      e.rk   = rks[i];
      e.idx  = IDX_W'(i);
      e.last = (i == 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per accepted beat and checks stall stability.
  logic             hold_q = 1'b0;
  logic [63:0]      hold_rk;
  logic [IDX_W-1:0] hold_idx;
  exp_t             m_e;

  always @(negedge clock) begin
    if (!mon_en) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 80'(rk_valid), 80'(1));
        chk("hold_rk", 80'(rk_out), 80'(hold_rk));
        chk("hold_idx", 80'(rk_idx), 80'(hold_idx));
      end
      if (rk_valid && rk_ready) begin
        beats++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL extra_beat: got beat idx %0d expected no beat", rk_idx);
        end else begin
          m_e = sb.pop_front();
          chk("rk_out", 80'(rk_out), 80'(m_e.rk));
          chk("rk_idx", 80'(rk_idx), 80'(m_e.idx));
          chk("rk_last", 80'(rk_last), 80'(m_e.last));
        end
        hold_q = 1'b0;
      end else if (rk_valid) begin
        hold_q   = 1'b1;
        hold_rk  = rk_out;
        hold_idx = rk_idx;
      end else begin
        hold_q = 1'b0;
      end
    end
  end

  // mode 0: ready high; 1: random ready; 2: stray start pulses during FWD and EMIT
  task automatic run(input logic [79:0] key, input int mode, input bit last_load);
    int cyc;
    int guard;
    beats = 0;
    @(posedge clock); #1;
    start    = 1'b1;
    key_in   = key;
`ifdef PRESENT_LAST_KEY_LOAD_EN
    key_is_last = last_load;
`endif
    rk_ready = (mode != 1);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      start = 1'b0;
`ifdef PRESENT_LAST_KEY_LOAD_EN
      key_is_last = 1'b0;
`endif
      cyc++;
      if (mode == 2 && cyc == 5) begin
        start  = 1'b1;
        key_in = ~key;
      end
    end while (!rk_valid && cyc < 200);
    chk("first_valid_latency", 80'(cyc), last_load ? 80'(1) : 80'(ROUNDS));
    guard = 0;
    while (busy && guard < 2000) begin
      if (mode == 1) rk_ready = 1'($urandom_range(0, 1));
      if (mode == 2 && guard == 3) begin
        start  = 1'b1;
        key_in = key ^ 80'h1234;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      guard++;
    end
    start = 1'b0;
    chk("beat_count", 80'(beats), 80'(ROUNDS));
    chk("scoreboard_empty", 80'(sb.size()), 80'(0));
    chk("busy_after", 80'(busy), 80'(0));
  endtask

`ifdef PRESENT_LAST_KEY_LOAD_EN
  function automatic logic [79:0] final_state(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 1; i < ROUNDS; i++) k = fwd_step(k, 5'(i));
    return k;
  endfunction
`endif

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 80'(busy), 80'(0));
    chk({tag, "_valid"}, 80'(rk_valid), 80'(0));
    chk({tag, "_last"}, 80'(rk_last), 80'(0));
    chk({tag, "_idx"}, 80'(rk_idx), 80'(0));
    chk({tag, "_out"}, 80'(rk_out), 80'(0));
  endtask

  initial begin
    logic [95:0] rnd;
    int          guard;
    reset_n  = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
`ifdef PRESENT_LAST_KEY_LOAD_EN
    key_is_last = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    push_expected(80'h0, 1'b1);
    run(80'h0, 0, 1'b0);

    push_expected({80{1'b1}}, 1'b0);
    run({80{1'b1}}, 0, 1'b0);

    push_expected(80'h0123456789abcdef0123, 1'b0);
    run(80'h0123456789abcdef0123, 1, 1'b0);

    for (int n = 0; n < 100; n++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      push_expected(rnd[79:0], 1'b0);
      run(rnd[79:0], n % 2, 1'b0);
    end

    push_expected(80'hfedcba98765432100f0f, 1'b0);
    run(80'hfedcba98765432100f0f, 2, 1'b0);

    push_expected(80'h5a5a5a5a5a5a5a5a5a5a, 1'b0);
    @(posedge clock); #1;
    start    = 1'b1;
    key_in   = 80'h5a5a5a5a5a5a5a5a5a5a;
    rk_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    guard = 0;
    while (!(rk_valid && rk_idx == IDX_W'(17)) && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("reached_idx17", 80'(rk_idx), 80'(17));
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    push_expected(80'h0, 1'b1);
    run(80'h0, 1, 1'b0);

`ifdef PRESENT_LAST_KEY_LOAD_EN
    push_expected(80'h0, 1'b1);
    run(final_state(80'h0), 0, 1'b1);
`endif

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
